cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- 32-bit single-bus CPU datapath for the course processor.
- Contains 16 GPRs (R0–R15), HI, LO, PC, IR, MAR, MDR, Y, a 64-bit Z, an Inport register, a C (immediate) register, a bus multiplexer and the ALU.
- The external control unit (a testbench at this phase) drives every register-enable and bus-select strobe. The block executes register-transfer micro-steps one clock at a time.

Parameters:
- WIDTH, 32, datapath word width. Z is 2*WIDTH.

Ports:
- Clock  in  1  system clock; all registers update on the rising edge.
- clear  in  1  asynchronous active-low reset.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- IncPC  in  1  ALU override: Z <= bus + 1.
- opcode  in  5  ALU operation select.
- R0in..R15in  in  1 each  GPR load enables.
- HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin  in  1 each  register load enables.
- R0out..R15out  in  1 each  GPR bus drive selects.
- HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout, Inportout, Cout  in  1 each  bus drive selects.
- Mdatain  in  32  memory read data.
- BusMuxOut  out  32  current bus value, for observation.

Behaviour:
- Reset: clear=0 asynchronously zeroes every register (R0–R15, HI, LO, PC, IR, MAR, MDR, Y, Z, Inport, C). BusMuxOut is then 0.
- Bus: purely combinational mux driven by the asserted *out select.
  - Priority if several selects are high: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, Inport, C, Y, IR, MAR.
  - No select high drives 0.
- Register loads: on a rising edge with Xin=1, register X takes the bus value. Otherwise it holds.
- MDR: on MDRin it loads (Read ? Mdatain : bus).
- Z: on Zin it loads the 64-bit ALU result C[63:0].
  - Zhighout drives Z[63:32]; Zlowout drives Z[31:0].
- ALU operands: A = Y, B = bus. Result is 64-bit; the upper half is 0 unless stated otherwise.
- IncPC=1 overrides opcode: result = B + 1.
- Opcode map:
  - 00011 add A+B
  - 00100 sub A−B
  - 00101 shr A>>B[4:0] logical
  - 00110 shra arithmetic right
  - 00111 shl A<<B[4:0]
  - 01000 ror rotate A right by B[4:0]
  - 01001 rol rotate left
  - 01010 and
  - 01011 or
  - 01100 addi A+B
  - 01101 andi
  - 01110 ori
  - 01111 mul: signed A*B, full 64-bit result
  - 10000 div: signed; Zlow = quotient, Zhigh = remainder; B=0 gives result 0
  - 10001 neg −B
  - 10010 not ~B
  - any other opcode gives result 0
- Add/sub wrap modulo 2^32. Shift/rotate amount of 0 passes A unchanged.
- Simultaneous load and drive of the same register in one cycle: the bus shows the old value and the register captures the bus value at the edge.
- R0 is an ordinary register; there is no hard-wired zero at this phase.
- A reset asserted mid-sequence wins immediately, regardless of the enables.

Test Plan:
- Reset: clear low, then high → BusMuxOut=0 with PCout=1, and all registers read 0.
- ROR sequence:
  - Mdatain=8, Read=1, MDRin=1 for 1 cycle; then MDRout, R2in → R2=8.
  - Load R3=2 and R1=8 the same way.
  - R2out+Yin; then R3out, opcode=01000, Zin; then Zlowout+R1in → R1=0x00000002.
- Fetch:
  - T0 with PCout, MARin, IncPC, Zin, PC=0 → MAR=0, Zlow=1.
  - T1 with Zlowout, PCin, Read, MDRin, Mdatain=0x18918000 → PC=1, MDR=0x18918000.
  - T2 with MDRout+IRin → IR=0x18918000.
- Arithmetic: Y=0xFFFFFFFF, bus=1, add → Zlow=0; mul of −2 and 3 → Z=0xFFFFFFFF_FFFFFFFA.
- Div: Y=17, bus=5 → Zlow=3, Zhigh=2. Bus=0 → Z=0.
- Bus idle/priority: no select high → BusMuxOut=0. R1out and R2out both high → R1 value on bus.

Source files
------------

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit course-processor datapath: register file, special registers,
// bus multiplexer and ALU, sequenced one micro-step per clock by an external control unit.
module cpu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             Read,
  input  logic             IncPC,
  input  logic [4:0]       opcode,
  input  logic             R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic             R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             Yin,
  input  logic             Zin,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             Inportin,
  input  logic             Cin,
  input  logic             R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic             R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             Yout,
  input  logic             Zhighout,
  input  logic             Zlowout,
  input  logic             PCout,
  input  logic             IRout,
  input  logic             MARout,
  input  logic             MDRout,
  input  logic             Inportout,
  input  logic             Cout,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] BusMuxOut
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_SHR  = 5'b00101,
    OP_SHRA = 5'b00110,
    OP_SHL  = 5'b00111,
    OP_ROR  = 5'b01000,
    OP_ROL  = 5'b01001,
    OP_AND  = 5'b01010,
    OP_OR   = 5'b01011,
    OP_ADDI = 5'b01100,
    OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  logic [15:0] gpr_in, gpr_out;
  assign gpr_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign gpr_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  logic [15:0][WIDTH-1:0] gpr;
  logic [WIDTH-1:0]       hi, lo, pc, ir, mar, mdr, y, inport, c_reg;
  logic [2*WIDTH-1:0]     z;
  logic [WIDTH-1:0]       bus;

  // Bus: fixed priority, R0 highest, MAR lowest; nothing selected reads as zero.
  always_comb begin
    bus = '0;
    if (|gpr_out) begin
      for (int i = 15; i >= 0; i--) begin
        if (gpr_out[i]) bus = gpr[i];
      end
    end
    else if (HIout)     bus = hi;
    else if (LOout)     bus = lo;
    else if (Zhighout)  bus = z[2*WIDTH-1:WIDTH];
    else if (Zlowout)   bus = z[WIDTH-1:0];
    else if (PCout)     bus = pc;
    else if (MDRout)    bus = mdr;
    else if (Inportout) bus = inport;
    else if (Cout)      bus = c_reg;
    else if (Yout)      bus = y;
    else if (IRout)     bus = ir;
    else if (MARout)    bus = mar;
  end

  assign BusMuxOut = bus;

  // ALU operands are fixed: A comes from Y, B is whatever is on the bus this cycle.
  logic [SHW-1:0]             shamt;
  logic [2*WIDTH-1:0]         rot_r, rot_l;
  logic signed [2*WIDTH-1:0]  mul_a, mul_b, product;
  logic signed [WIDTH-1:0]    div_a, div_b, quot, rem;

  assign shamt   = bus[SHW-1:0];
  assign rot_r   = {y, y} >> shamt;
  assign rot_l   = {y, y} << shamt;
  assign mul_a   = {{WIDTH{y[WIDTH-1]}}, y};
  assign mul_b   = {{WIDTH{bus[WIDTH-1]}}, bus};
  assign product = mul_a * mul_b;
  assign div_a   = y;
  assign div_b   = bus;
  assign quot    = div_a / div_b;
  assign rem     = div_a % div_b;

  logic [WIDTH-1:0] res_lo, res_hi;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    res_lo = '0;
    res_hi = '0;
    if (IncPC) begin
      res_lo = bus + ONE;
    end else begin
      case (opcode)
        OP_ADD, OP_ADDI: res_lo = y + bus;
        OP_SUB:          res_lo = y - bus;
        OP_SHR:          res_lo = y >> shamt;
        OP_SHRA:         res_lo = $signed(y) >>> shamt;
        OP_SHL:          res_lo = y << shamt;
        OP_ROR:          res_lo = rot_r[WIDTH-1:0];
        OP_ROL:          res_lo = rot_l[2*WIDTH-1:WIDTH];
        OP_AND, OP_ANDI: res_lo = y & bus;
        OP_OR,  OP_ORI:  res_lo = y | bus;
        OP_MUL:          {res_hi, res_lo} = product;
        OP_DIV: begin
          if (bus != '0) begin
            res_lo = quot;
            res_hi = rem;
          end
        end
        OP_NEG:          res_lo = -bus;
        OP_NOT:          res_lo = ~bus;
        default: ;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples the pre-edge bus.
  // NOTE: the register file lives in flops, not RAM, because reset must zero all sixteen GPRs.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      gpr    <= '0;
      hi     <= '0;
      lo     <= '0;
      pc     <= '0;
      ir     <= '0;
      mar    <= '0;
      mdr    <= '0;
      y      <= '0;
      z      <= '0;
      inport <= '0;
      c_reg  <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (gpr_in[i]) gpr[i] <= bus;
      end
      if (HIin)     hi     <= bus;
      if (LOin)     lo     <= bus;
      if (PCin)     pc     <= bus;
      if (IRin)     ir     <= bus;
      if (MARin)    mar    <= bus;
      if (MDRin)    mdr    <= Read ? Mdatain : bus;
      if (Yin)      y      <= bus;
      if (Zin)      z      <= {res_hi, res_lo};
      if (Inportin) inport <= bus;
      if (Cin)      c_reg  <= bus;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed micro-step bench for cpu_datapath: stimulus queues expected bus values,
// a negedge monitor pops and compares them against BusMuxOut.
module tb_cpu_datapath;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        Read, IncPC;
  logic [4:0]  opcode;
  logic [15:0] r_in, r_out;
  logic        hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in, inport_in, c_in;
  logic        hi_out, lo_out, y_out, zhigh_out, zlow_out, pc_out, ir_out, mar_out;
  logic        mdr_out, inport_out, c_out;
  logic [31:0] mdatain;
  logic [31:0] bus;

  cpu_datapath #(.WIDTH(32)) dut (
    .Clock(Clock), .clear(clear), .Read(Read), .IncPC(IncPC), .opcode(opcode),
    .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
    .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
    .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .HIin(hi_in), .LOin(lo_in), .Yin(y_in), .Zin(z_in), .PCin(pc_in), .IRin(ir_in),
    .MARin(mar_in), .MDRin(mdr_in), .Inportin(inport_in), .Cin(c_in),
    .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
    .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
    .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .HIout(hi_out), .LOout(lo_out), .Yout(y_out), .Zhighout(zhigh_out), .Zlowout(zlow_out),
    .PCout(pc_out), .IRout(ir_out), .MARout(mar_out), .MDRout(mdr_out),
    .Inportout(inport_out), .Cout(c_out),
    .Mdatain(mdatain), .BusMuxOut(bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  typedef enum int {S_HI, S_LO, S_ZH, S_ZL, S_PC, S_MDR, S_IN, S_C, S_Y, S_IR, S_MAR} sel_e;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } alu_vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic chk_en = 1'b0;

  // Monitor: mid-cycle, whenever stimulus flags an observation, compare the bus with the queue head.
  initial begin
    forever begin
      @(negedge Clock);
      if (chk_en) begin
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_sample: bus=%h with no expected entry", bus);
        end else begin
          e = sb.pop_front();
          if (bus !== e.value) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, bus, e.value);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    Read = 0; IncPC = 0; opcode = '0; mdatain = '0;
    r_in = '0; r_out = '0;
    hi_in = 0; lo_in = 0; y_in = 0; z_in = 0; pc_in = 0; ir_in = 0;
    mar_in = 0; mdr_in = 0; inport_in = 0; c_in = 0;
    hi_out = 0; lo_out = 0; y_out = 0; zhigh_out = 0; zlow_out = 0; pc_out = 0;
    ir_out = 0; mar_out = 0; mdr_out = 0; inport_out = 0; c_out = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_bus(input string n, input logic [31:0] v);
    sb.push_back('{name: n, value: v});
    chk_en = 1'b1;
    tick();
    chk_en = 1'b0;
  endtask

  task automatic drive_sel(input sel_e s);
    case (s)
      S_HI:  hi_out     = 1;
      S_LO:  lo_out     = 1;
      S_ZH:  zhigh_out  = 1;
      S_ZL:  zlow_out   = 1;
      S_PC:  pc_out     = 1;
      S_MDR: mdr_out    = 1;
      S_IN:  inport_out = 1;
      S_C:   c_out      = 1;
      S_Y:   y_out      = 1;
      S_IR:  ir_out     = 1;
      default: mar_out  = 1;
    endcase
  endtask

  task automatic read_sel(input string n, input sel_e s, input logic [31:0] v);
    idle();
    drive_sel(s);
    expect_bus(n, v);
    idle();
  endtask

  task automatic read_gpr(input string n, input int i, input logic [31:0] v);
    idle();
    r_out[i] = 1;
    expect_bus(n, v);
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle();
    mdatain = v; Read = 1; mdr_in = 1;
    tick();
    idle();
  endtask

  task automatic mdr_to_gpr(input int i, input logic [31:0] v);
    load_mdr(v);
    mdr_out = 1; r_in[i] = 1;
    tick();
    idle();
  endtask

  task automatic alu_check(input alu_vec_t t);
    load_mdr(t.a);
    mdr_out = 1; y_in = 1;
    tick();
    idle();
    load_mdr(t.b);
    mdr_out = 1; z_in = 1; opcode = t.op;
    tick();
    idle();
    read_sel({t.name, "_lo"}, S_ZL, t.lo);
    read_sel({t.name, "_hi"}, S_ZH, t.hi);
  endtask

  alu_vec_t alu_tab[$] = '{
    '{"mul_neg",   5'b01111, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA},
    '{"div",       5'b10000, 32'd17,        32'd5,         32'd2,         32'd3},
    '{"div_neg",   5'b10000, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD},
    '{"sub",       5'b00100, 32'd17,        32'd5,         32'd0,         32'd12},
    '{"sub_wrap",  5'b00100, 32'd5,         32'd17,        32'd0,         32'hFFFF_FFF4},
    '{"shr",       5'b00101, 32'h8000_0000, 32'd4,         32'd0,         32'h0800_0000},
    '{"shra",      5'b00110, 32'h8000_0000, 32'd4,         32'd0,         32'hF800_0000},
    '{"shl",       5'b00111, 32'h0000_0001, 32'd31,        32'd0,         32'h8000_0000},
    '{"ror_zero",  5'b01000, 32'h1234_5678, 32'd0,         32'd0,         32'h1234_5678},
    '{"ror_32",    5'b01000, 32'h1234_5678, 32'd32,        32'd0,         32'h1234_5678},
    '{"rol",       5'b01001, 32'h8000_0001, 32'd1,         32'd0,         32'h0000_0003},
    '{"and",       5'b01010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,         32'hF000_F000},
    '{"or",        5'b01011, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'd0,         32'hFFFF_F0F0},
    '{"addi",      5'b01100, 32'd7,         32'd8,         32'd0,         32'd15},
    '{"andi",      5'b01101, 32'h0000_00FF, 32'h0000_000F, 32'd0,         32'h0000_000F},
    '{"ori",       5'b01110, 32'h0000_00F0, 32'h0000_000F, 32'd0,         32'h0000_00FF},
    '{"neg",       5'b10001, 32'd9,         32'd5,         32'd0,         32'hFFFF_FFFB},
    '{"not",       5'b10010, 32'd9,         32'd5,         32'd0,         32'hFFFF_FFFA},
    '{"illegal",   5'b00000, 32'd3,         32'd4,         32'd0,         32'd0},
    '{"mul_big",   5'b01111, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0}
  };

  initial begin
    idle();
    #1 clear = 0;
    repeat (2) @(posedge Clock);
    #1 clear = 1;

    // Reset state: every register reads back zero.
    pc_out = 1;
    expect_bus("rst_pc_bus", 32'd0);
    idle();
    for (int i = 0; i < 16; i++) read_gpr($sformatf("rst_r%0d", i), i, 32'd0);
    for (int s = 0; s <= int'(S_MAR); s++) read_sel($sformatf("rst_sel%0d", s), sel_e'(s), 32'd0);

    // ROR sequence: R1 <= ror(R2=8, R3=2).
    mdr_to_gpr(2, 32'd8);
    mdr_to_gpr(3, 32'd2);
    mdr_to_gpr(1, 32'd8);
    r_out[2] = 1; y_in = 1;
    tick();
    idle();
    r_out[3] = 1; opcode = 5'b01000; z_in = 1;
    tick();
    idle();
    zlow_out = 1; r_in[1] = 1;
    expect_bus("ror_zlow_bus", 32'd2);
    idle();
    read_gpr("ror_r1", 1, 32'd2);

    // Bus idle and priority.
    expect_bus("idle_bus", 32'd0);
    r_out[1] = 1; r_out[2] = 1;
    expect_bus("prio_r1_over_r2", 32'd2);
    idle();
    r_out[3] = 1; hi_out = 1; mar_out = 1;
    expect_bus("prio_r3_over_hi", 32'd2);
    idle();

    // Fetch T0..T2.
    pc_out = 1; mar_in = 1; IncPC = 1; z_in = 1;
    expect_bus("t0_bus", 32'd0);
    idle();
    read_sel("t0_zlow", S_ZL, 32'd1);
    read_sel("t0_mar", S_MAR, 32'd0);
    zlow_out = 1; pc_in = 1; Read = 1; mdr_in = 1; mdatain = 32'h1891_8000;
    expect_bus("t1_bus", 32'd1);
    idle();
    read_sel("t1_pc", S_PC, 32'd1);
    mdr_out = 1; ir_in = 1;
    expect_bus("t2_bus", 32'h1891_8000);
    idle();
    read_sel("t2_ir", S_IR, 32'h1891_8000);

    // Add with carry-out discarded: Y=FFFFFFFF, bus=PC=1.
    load_mdr(32'hFFFF_FFFF);
    mdr_out = 1; y_in = 1;
    tick();
    idle();
    pc_out = 1; opcode = 5'b00011; z_in = 1;
    tick();
    idle();
    read_sel("add_wrap_lo", S_ZL, 32'd0);
    read_sel("add_wrap_hi", S_ZH, 32'd0);

    foreach (alu_tab[i]) alu_check(alu_tab[i]);

    // Divide by zero with an idle bus (B=0); Z currently holds a nonzero value.
    load_mdr(32'd17);
    mdr_out = 1; y_in = 1;
    tick();
    idle();
    opcode = 5'b10000; z_in = 1;
    tick();
    idle();
    read_sel("div0_lo", S_ZL, 32'd0);
    read_sel("div0_hi", S_ZH, 32'd0);

    // Remaining bus-loaded registers, and MDR loading from the bus when Read=0.
    load_mdr(32'hA5A5_0001); mdr_out = 1; hi_in = 1;     tick(); idle();
    load_mdr(32'hA5A5_0002); mdr_out = 1; lo_in = 1;     tick(); idle();
    load_mdr(32'hA5A5_0003); mdr_out = 1; inport_in = 1; tick(); idle();
    load_mdr(32'hA5A5_0004); mdr_out = 1; c_in = 1;      tick(); idle();
    read_sel("hi_load", S_HI, 32'hA5A5_0001);
    read_sel("lo_load", S_LO, 32'hA5A5_0002);
    read_sel("inport_load", S_IN, 32'hA5A5_0003);
    read_sel("c_load", S_C, 32'hA5A5_0004);
    r_out[1] = 1; mdr_in = 1; mdatain = 32'hDEAD_BEEF;
    tick();
    idle();
    read_sel("mdr_from_bus", S_MDR, 32'd2);

    // Reset asserted mid-cycle with enables high wins immediately.
    mdr_to_gpr(5, 32'h0000_0055);
    read_gpr("r5_before_rst", 5, 32'h0000_0055);
    mdr_out = 1; r_in[5] = 1; y_in = 1;
    #1 clear = 0;
    expect_bus("async_rst_bus", 32'd0);
    clear = 1;
    idle();
    read_gpr("async_rst_r5", 5, 32'd0);
    read_sel("async_rst_pc", S_PC, 32'd0);
    read_sel("async_rst_hi", S_HI, 32'd0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clock);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries never observed, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
